// File: rtl/dec_stream_checker.sv
// Purpose : frame-based, multi-lane masked compare of decoded (A) vs expected (B) words,
//           with per-frame mismatch count, first-failing-beat capture and end-of-frame verdict.
// Latency : 1 cycle from accepted beat to out_valid/lane_eq/counters; verdict with the last beat's result.
// Backpressure: in_ready only in RUN and never while start is high; IDLE and DONE refuse beats.
// Ports   : clk, rst (async, active-low); start pulse opens a frame; in_valid/in_ready handshake
//           carries A/B/mask/last; out_valid, lane_eq, all_eq give the per-beat result; err_cnt,
//           first_err_valid/idx, frame_done, frame_pass give the frame verdict; busy = not IDLE.
module dec_stream_checker #(
    parameter int DATA_DEPTH = 8,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_DEPTH-1:0] A,
    input  logic [LANES*DATA_DEPTH-1:0] B,
    input  logic [LANES*DATA_DEPTH-1:0] mask,
    input  logic                        last,
    output logic                        out_valid,
    output logic [LANES-1:0]            lane_eq,
    output logic                        all_eq,
    output logic [CNT_WIDTH-1:0]        err_cnt,
    output logic                        first_err_valid,
    output logic [CNT_WIDTH-1:0]        first_err_idx,
    output logic                        frame_done,
    output logic                        frame_pass,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic [LANES-1:0]     lane_eq_cmb;
    logic                 beat_err;
    logic [CNT_WIDTH-1:0] beat_idx;
    logic [CNT_WIDTH-1:0] err_cnt_nxt;

    // Masked bits never contribute, so a fully masked lane always compares equal.
    always_comb begin
        lane_eq_cmb = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_eq_cmb[i] = ~|((A[i*DATA_DEPTH +: DATA_DEPTH] ^ B[i*DATA_DEPTH +: DATA_DEPTH])
                                & ~mask[i*DATA_DEPTH +: DATA_DEPTH]);
        end
    end

    assign beat_err = ~&lane_eq_cmb;

    // start wins over a beat offered in the same cycle: that beat is dropped.
    assign in_ready = (state == RUN) & ~start;
    assign accept   = in_valid & in_ready;

    // Error count including the current beat; frame_pass is judged on this value
    // so the last beat of the frame is already accounted for.
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (accept && beat_err && (err_cnt != CNT_MAX)) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (accept && last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            out_valid       <= 1'b0;
            lane_eq         <= '0;
            all_eq          <= 1'b0;
            beat_idx        <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            frame_done      <= 1'b0;
            frame_pass      <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            out_valid  <= accept;
            frame_done <= accept & last;

            // Per-beat result holds between accepted beats.
            if (accept) begin
                lane_eq <= lane_eq_cmb;
                all_eq  <= &lane_eq_cmb;
            end

            if (start) begin
                beat_idx        <= '0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                frame_pass      <= 1'b0;
            end else if (accept) begin
                if (beat_idx != CNT_MAX) begin
                    beat_idx <= beat_idx + 1'b1;
                end
                err_cnt <= err_cnt_nxt;
                // Index captured pre-increment, so it is the 0-based index of this beat.
                if (beat_err && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= beat_idx;
                end
                if (last) begin
                    frame_pass <= (err_cnt_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_dec_stream_checker.sv
module tb_dec_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mask;

    logic        in_ready;
    logic        out_valid;
    logic [3:0]  lane_eq;
    logic        all_eq;
    logic [15:0] err_cnt;
    logic        first_err_valid;
    logic [15:0] first_err_idx;
    logic        frame_done;
    logic        frame_pass;
    logic        busy;

    logic        in_ready3;
    logic        out_valid3;
    logic [3:0]  lane_eq3;
    logic        all_eq3;
    logic [2:0]  err_cnt3;
    logic        first_err_valid3;
    logic [2:0]  first_err_idx3;
    logic        frame_done3;
    logic        frame_pass3;
    logic        busy3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dec_stream_checker #(.DATA_DEPTH(8), .LANES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .mask(mask), .last(last),
        .out_valid(out_valid), .lane_eq(lane_eq), .all_eq(all_eq), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .frame_done(frame_done), .frame_pass(frame_pass), .busy(busy)
    );

    // Narrow-counter instance for saturation, fed the same stimulus.
    dec_stream_checker #(.DATA_DEPTH(8), .LANES(4), .CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready3),
        .A(a), .B(b), .mask(mask), .last(last),
        .out_valid(out_valid3), .lane_eq(lane_eq3), .all_eq(all_eq3), .err_cnt(err_cnt3),
        .first_err_valid(first_err_valid3), .first_err_idx(first_err_idx3),
        .frame_done(frame_done3), .frame_pass(frame_pass3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat for exactly one edge; returns 1 ns after that edge.
    task automatic send(input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] mi, input logic lst);
        in_valid = 1'b1;
        a        = ai;
        b        = bi;
        mask     = mi;
        last     = lst;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},        32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid},       32'd0);
        chk({tag, "_lane_eq"},   {28'd0, lane_eq},         32'd0);
        chk({tag, "_all_eq"},    {31'd0, all_eq},          32'd0);
        chk({tag, "_err_cnt"},   {16'd0, err_cnt},         32'd0);
        chk({tag, "_fev"},       {31'd0, first_err_valid}, 32'd0);
        chk({tag, "_fei"},       {16'd0, first_err_idx},   32'd0);
        chk({tag, "_done"},      {31'd0, frame_done},      32'd0);
        chk({tag, "_pass"},      {31'd0, frame_pass},      32'd0);
        chk({tag, "_busy"},      {31'd0, busy},            32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] bad;

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
        a        = '0;
        b        = '0;
        mask     = '0;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Frame 1: 4 clean beats
        do_start();
        #1;
        chk("f1_busy", {31'd0, busy}, 32'd1);
        chk("f1_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            d = 32'h01020304 * (i + 1);
            send(d, d, 32'd0, (i == 3));
            chk("f1_out_valid", {31'd0, out_valid}, 32'd1);
            chk("f1_all_eq", {31'd0, all_eq}, 32'd1);
            chk("f1_lane_eq", {28'd0, lane_eq}, 32'hf);
            chk("f1_done", {31'd0, frame_done}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("f1_pass", {31'd0, frame_pass}, 32'd1);
        chk("f1_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("f1_fev", {31'd0, first_err_valid}, 32'd0);
        chk("f1_busy_done", {31'd0, busy}, 32'd1);
        tick();
        chk("f1_done_clr", {31'd0, frame_done}, 32'd0);
        chk("f1_out_valid_idle", {31'd0, out_valid}, 32'd0);
        chk("f1_busy_idle", {31'd0, busy}, 32'd0);
        chk("f1_pass_hold", {31'd0, frame_pass}, 32'd1);
        chk("f1_lane_eq_hold", {28'd0, lane_eq}, 32'hf);

        // Frame 2: lane 2 bit 0 corrupted on beats 2 and 5
        do_start();
        for (int i = 0; i < 6; i++) begin
            d = 32'hA0B0C0D0 + i;
            bad = (i == 2 || i == 5) ? 32'h0001_0000 : 32'd0;
            send(d ^ bad, d, 32'd0, (i == 5));
            chk("f2_lane_eq", {28'd0, lane_eq}, (bad != 0) ? 32'hb : 32'hf);
            chk("f2_all_eq", {31'd0, all_eq}, (bad != 0) ? 32'd0 : 32'd1);
            if (i == 2) chk("f2_err_mid", {16'd0, err_cnt}, 32'd1);
        end
        chk("f2_done", {31'd0, frame_done}, 32'd1);
        chk("f2_err_cnt", {16'd0, err_cnt}, 32'd2);
        chk("f2_fev", {31'd0, first_err_valid}, 32'd1);
        chk("f2_fei", {16'd0, first_err_idx}, 32'd2);
        chk("f2_pass", {31'd0, frame_pass}, 32'd0);

        // Frame 3: start during DONE, same corruption masked out
        do_start();
        chk("f3_busy", {31'd0, busy}, 32'd1);
        chk("f3_done_none", {31'd0, frame_done}, 32'd0);
        chk("f3_err_clr", {16'd0, err_cnt}, 32'd0);
        chk("f3_fev_clr", {31'd0, first_err_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            d = 32'hA0B0C0D0 + i;
            bad = (i == 2 || i == 5) ? 32'h0001_0000 : 32'd0;
            send(d ^ bad, d, 32'h0001_0000, (i == 5));
            chk("f3_all_eq", {31'd0, all_eq}, 32'd1);
        end
        chk("f3_done", {31'd0, frame_done}, 32'd1);
        chk("f3_pass", {31'd0, frame_pass}, 32'd1);
        chk("f3_err_cnt", {16'd0, err_cnt}, 32'd0);
        tick();

        // Frame 4: in_valid held in IDLE, across start, abort, DONE
        in_valid = 1'b1;
        a = 32'h00000001;
        b = 32'h00000000;
        mask = 32'd0;
        #1;
        chk("f4_idle_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("f4_idle_ov", {31'd0, out_valid}, 32'd0);
        start = 1'b1;
        #1;
        chk("f4_start_ready", {31'd0, in_ready}, 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("f4_start_drop", {31'd0, out_valid}, 32'd0);
        chk("f4_err_after_start", {16'd0, err_cnt}, 32'd0);
        send(32'h1, 32'h0, 32'd0, 1'b0);
        send(32'h1, 32'h0, 32'd0, 1'b0);
        chk("f4_err_two", {16'd0, err_cnt}, 32'd2);
        chk("f4_lane_eq", {28'd0, lane_eq}, 32'he);
        // Abort with a beat offered alongside start
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("f4_abort_ov", {31'd0, out_valid}, 32'd0);
        chk("f4_abort_done", {31'd0, frame_done}, 32'd0);
        chk("f4_abort_err", {16'd0, err_cnt}, 32'd0);
        chk("f4_abort_fev", {31'd0, first_err_valid}, 32'd0);
        // One-beat frame
        send(32'h1, 32'h0, 32'd0, 1'b1);
        chk("f4_one_done", {31'd0, frame_done}, 32'd1);
        chk("f4_one_err", {16'd0, err_cnt}, 32'd1);
        chk("f4_one_fei", {16'd0, first_err_idx}, 32'd0);
        chk("f4_one_pass", {31'd0, frame_pass}, 32'd0);
        in_valid = 1'b1;
        #1;
        chk("f4_done_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("f4_after_ov", {31'd0, out_valid}, 32'd0);
        chk("f4_after_busy", {31'd0, busy}, 32'd0);
        chk("f4_err_hold", {16'd0, err_cnt}, 32'd1);
        chk("f4_fev_hold", {31'd0, first_err_valid}, 32'd1);

        // Frame 5: saturation on the 3-bit counter instance
        do_start();
        for (int i = 0; i < 10; i++) begin
            send(32'hFF, 32'h00, 32'd0, (i == 9));
        end
        chk("f5_err3_sat", {29'd0, err_cnt3}, 32'd7);
        chk("f5_err16", {16'd0, err_cnt}, 32'd10);
        chk("f5_fei3", {29'd0, first_err_idx3}, 32'd0);
        chk("f5_done3", {31'd0, frame_done3}, 32'd1);
        tick();
        // 9 clean beats then a bad one: beat index must saturate, not wrap
        do_start();
        for (int i = 0; i < 10; i++) begin
            send((i == 9) ? 32'h10 : 32'h0, 32'h0, 32'd0, (i == 9));
        end
        chk("f5_fei3_sat", {29'd0, first_err_idx3}, 32'd7);
        chk("f5_fei16", {16'd0, first_err_idx}, 32'd9);
        chk("f5_err3_one", {29'd0, err_cnt3}, 32'd1);
        chk("f5_pass3", {31'd0, frame_pass3}, 32'd0);
        tick();

        // Frame 6: asynchronous reset mid-frame
        do_start();
        for (int i = 0; i < 3; i++) begin
            send(32'h1, 32'h0, 32'd0, 1'b0);
        end
        chk("f6_err_pre", {16'd0, err_cnt}, 32'd3);
        chk("f6_ov_pre", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        last     = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("f6_rst");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f6_no_done", {31'd0, frame_done}, 32'd0);
            chk("f6_no_busy", {31'd0, busy}, 32'd0);
            chk("f6_no_ov", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        last     = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
